branch_trap_sequencer: RTL and testbench
========================================

# branch_trap_sequencer

Sequences control flow around the branch/trap condition tester. It takes the tester's BCOND/TCOND verdicts together with decode information and drives next-PC selection and delay-slot annulment. It also runs the multi-cycle trap-entry sequence: save PC/nPC, rotate CWP, update PSR and vector to TBR. It sits between decode and the PC/nPC registers, and owns the PSR write strobe during trap entry.

## Interface
Parameters:
- NWIN, 4, number of register windows; CWP width is log2(NWIN) = 2.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  reset; synchronous and active-low
- instr_valid  in  1  decoded instruction present this cycle
- is_bicc  in  1  instruction is Bicc
- is_ticc  in  1  instruction is Ticc
- cond  in  4  IR[28:25]
- annul_bit  in  1  IR[29]
- bcond  in  1  condition tester branch verdict
- tcond  in  1  condition tester trap verdict
- sw_trap  in  7  Ticc software trap number (rs1+imm low 7 bits)
- trap_req  in  1  exception request from elsewhere in the pipeline
- trap_type_in  in  8  tt for trap_req
- et  in  1  PSR.ET
- s  in  1  PSR.S
- cwp  in  2  PSR.CWP
- pc_sel  out  2  00 sequential nPC, 01 branch target, 10 trap vector (TBR)
- annul  out  1  squash the instruction currently in the delay slot
- stall  out  1  freeze fetch and decode
- save_pc_we  out  1  write PC into local r17 of the new window
- save_npc_we  out  1  write nPC into local r18 of the new window
- psr_we  out  1  load PSR fields below
- psr_cwp  out  2  new CWP
- psr_ps  out  1  new PS
- psr_s  out  1  new S
- psr_et  out  1  new ET
- tt  out  8  trap type for TBR.tt
- error_mode  out  1  processor in error mode

## Operation
- States: RUN, ANNUL, T_SAVE_PC, T_SAVE_NPC, T_VECTOR, ERROR.
- Inputs are sampled at the rising edge. All outputs are registered and reflect the decision made at the previous edge.
- Priority within a cycle: trap_req > taken Ticc > Bicc > sequential.
- RUN, instr_valid=1:
  - trap_req=1: tt=trap_type_in, go to trap entry.
  - is_ticc & tcond: tt = {1'b1, sw_trap} (128 + n), go to trap entry.
  - is_bicc & bcond: pc_sel=01. If cond==4'b1000 (ba) and annul_bit=1, go to ANNUL; otherwise the delay slot executes and the state stays RUN.
  - is_bicc & !bcond: pc_sel=00. If annul_bit=1, go to ANNUL.
  - Otherwise: pc_sel=00.
- Trap entry:
  - If et=0: go to ERROR.
  - Else: go to T_SAVE_PC with stall=1.
- ANNUL: annul=1 for exactly one cycle. The next valid instruction is squashed: no branch, trap or trap_req is acted on. Then return to RUN. trap_req arriving in ANNUL is held off to the following cycle; the requester must keep it asserted.
- T_SAVE_PC: stall=1, save_pc_we=1, then T_SAVE_NPC.
- T_SAVE_NPC: stall=1, save_npc_we=1, then T_VECTOR.
- T_VECTOR, single cycle:
  - stall=1, psr_we=1, pc_sel=10
  - psr_cwp = (cwp-1) mod NWIN, so 0 wraps to 3
  - psr_ps=s, psr_s=1, psr_et=0
  - then RUN
- WIM is not checked on trap entry.
- trap_req, instr_valid and the condition verdicts are ignored in T_SAVE_PC, T_SAVE_NPC and T_VECTOR.
- ERROR: error_mode=1, stall=1, all strobes 0. ERROR is only left by reset.
- A Bicc in the delay slot of a taken branch (DCTI couple) is processed normally; its pc_sel overrides.

## Timing
- Reset value of every output is 0, and the state is RUN.
  - Covers pc_sel, annul, stall, save_pc_we, save_npc_we, psr_we, psr_cwp, psr_ps, psr_s, psr_et, tt, error_mode.
  - Reset asserted mid-sequence aborts the sequence with no further strobes.
- Branch decision latency: 1 cycle (pc_sel valid the cycle after the Bicc is sampled).
- annul asserts the cycle after the annulling Bicc and lasts exactly 1 cycle.
- Trap entry takes 3 stalled cycles: save_pc_we, then save_npc_we, then psr_we with pc_sel=10.
  - Each strobe is exactly 1 cycle wide.
  - tt is stable from T_SAVE_PC through T_VECTOR.
- ERROR asserts error_mode 1 cycle after the offending trap is sampled.
- In RUN, pc_sel returns to 00 after 1 cycle unless re-decided.

## Test plan
- Reset, then hold rst_n=0 for 2 cycles -> all outputs 0; release with no instr_valid -> pc_sel=00, state RUN.
- bne (cond=1001) with bcond=1, annul_bit=1 -> pc_sel=01 next cycle, annul stays 0. Then ba (cond=1000) with bcond=1, annul_bit=1 -> pc_sel=01 and annul=1 for one cycle.
- Untaken Bicc with annul_bit=1, and a Ticc with tcond=1 presented in the delay slot -> annul=1, no trap entered, stall stays 0.
- Ticc with tcond=1, sw_trap=7'h05, et=1, s=0, cwp=0 -> 3 stall cycles with save_pc_we, then save_npc_we, then psr_we. At psr_we: tt=8'h85, psr_cwp=3, psr_ps=0, psr_s=1, psr_et=0, pc_sel=10.
- trap_req=1 with trap_type_in=8'h2A and a taken Ticc in the same cycle -> tt=8'h2A (trap_req wins). trap_req pulsed again during T_SAVE_NPC -> ignored, one sequence only.
- Ticc with tcond=1 and et=0 -> error_mode=1 and stall=1 from the next cycle and held for 10 cycles; rst_n=0 for 1 cycle -> all outputs 0. Reset during T_SAVE_NPC -> no psr_we is ever issued.

Source files
------------

// File: rtl/branch_trap_sequencer.sv
// Branch/trap control-flow sequencer: next-PC selection, delay-slot annulment
// and the three-cycle trap entry (save PC, save nPC, PSR update + vector).
// All outputs are registered and reflect the decision taken at the last edge.
//
// state      | meaning
// RUN        | normal execution, decoding branch/trap verdicts
// ANNUL      | delay-slot instruction squashed, inputs ignored
// T_SAVE_PC  | trap entry: PC written to r17 of new window
// T_SAVE_NPC | trap entry: nPC written to r18 of new window
// T_VECTOR   | trap entry: PSR loaded, fetch redirected to TBR
// ERROR      | trap taken with ET=0, left only through reset
module branch_trap_sequencer #(
  parameter int NWIN = 4,
  localparam int CWPW = (NWIN > 1) ? $clog2(NWIN) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic            is_bicc,
  input  logic            is_ticc,
  input  logic [3:0]      cond,
  input  logic            annul_bit,
  input  logic            bcond,
  input  logic            tcond,
  input  logic [6:0]      sw_trap,
  input  logic            trap_req,
  input  logic [7:0]      trap_type_in,
  input  logic            et,
  input  logic            s,
  input  logic [CWPW-1:0] cwp,
  output logic [1:0]      pc_sel,
  output logic            annul,
  output logic            stall,
  output logic            save_pc_we,
  output logic            save_npc_we,
  output logic            psr_we,
  output logic [CWPW-1:0] psr_cwp,
  output logic            psr_ps,
  output logic            psr_s,
  output logic            psr_et,
  output logic [7:0]      tt,
  output logic            error_mode
);

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    ANNUL      = 3'd1,
    T_SAVE_PC  = 3'd2,
    T_SAVE_NPC = 3'd3,
    T_VECTOR   = 3'd4,
    ERROR      = 3'd5
  } state_t;

  localparam logic [1:0] SEL_SEQ    = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_TRAP   = 2'b10;
  localparam logic [3:0] COND_BA    = 4'b1000;

  state_t          state, state_nxt;
  logic [1:0]      pc_sel_nxt;
  logic            annul_nxt, stall_nxt, save_pc_we_nxt, save_npc_we_nxt;
  logic            psr_we_nxt, psr_ps_nxt, psr_s_nxt, psr_et_nxt, error_mode_nxt;
  logic [CWPW-1:0] psr_cwp_nxt;
  logic [7:0]      tt_nxt;
  logic            take_trap;
  logic [7:0]      trap_tt;

  // Trap source selection in RUN; trap_req outranks a taken Ticc.
  always_comb begin
    take_trap = 1'b0;
    trap_tt   = 8'h00;
    if (instr_valid && trap_req) begin
      take_trap = 1'b1;
      trap_tt   = trap_type_in;
    end else if (instr_valid && is_ticc && tcond) begin
      take_trap = 1'b1;
      trap_tt   = {1'b1, sw_trap};
    end
  end

  // Next state and next registered outputs; strobes default low every cycle.
  always_comb begin
    state_nxt       = state;
    pc_sel_nxt      = SEL_SEQ;
    annul_nxt       = 1'b0;
    stall_nxt       = 1'b0;
    save_pc_we_nxt  = 1'b0;
    save_npc_we_nxt = 1'b0;
    psr_we_nxt      = 1'b0;
    psr_cwp_nxt     = '0;
    psr_ps_nxt      = 1'b0;
    psr_s_nxt       = 1'b0;
    psr_et_nxt      = 1'b0;
    tt_nxt          = tt;
    error_mode_nxt  = 1'b0;
    unique case (state)
      RUN: begin
        if (take_trap) begin
          tt_nxt    = trap_tt;
          stall_nxt = 1'b1;
          if (!et) begin
            state_nxt      = ERROR;
            error_mode_nxt = 1'b1;
          end else begin
            state_nxt      = T_SAVE_PC;
            save_pc_we_nxt = 1'b1;
          end
        end else if (instr_valid && is_bicc) begin
          // Taken: only ba,a annuls. Untaken: any ,a annuls.
          if (bcond) begin
            pc_sel_nxt = SEL_BRANCH;
            if (annul_bit && cond == COND_BA) begin
              state_nxt = ANNUL;
              annul_nxt = 1'b1;
            end
          end else if (annul_bit) begin
            state_nxt = ANNUL;
            annul_nxt = 1'b1;
          end
        end
      end
      ANNUL: state_nxt = RUN;
      T_SAVE_PC: begin
        state_nxt       = T_SAVE_NPC;
        stall_nxt       = 1'b1;
        save_npc_we_nxt = 1'b1;
      end
      T_SAVE_NPC: begin
        state_nxt   = T_VECTOR;
        stall_nxt   = 1'b1;
        psr_we_nxt  = 1'b1;
        pc_sel_nxt  = SEL_TRAP;
        psr_cwp_nxt = (cwp == '0) ? CWPW'(NWIN - 1) : cwp - CWPW'(1);
        psr_ps_nxt  = s;
        psr_s_nxt   = 1'b1;
        psr_et_nxt  = 1'b0;
      end
      T_VECTOR: state_nxt = RUN;
      ERROR: begin
        stall_nxt      = 1'b1;
        error_mode_nxt = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      pc_sel      <= SEL_SEQ;
      annul       <= 1'b0;
      stall       <= 1'b0;
      save_pc_we  <= 1'b0;
      save_npc_we <= 1'b0;
      psr_we      <= 1'b0;
      psr_cwp     <= '0;
      psr_ps      <= 1'b0;
      psr_s       <= 1'b0;
      psr_et      <= 1'b0;
      tt          <= 8'h00;
      error_mode  <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc_sel      <= pc_sel_nxt;
      annul       <= annul_nxt;
      stall       <= stall_nxt;
      save_pc_we  <= save_pc_we_nxt;
      save_npc_we <= save_npc_we_nxt;
      psr_we      <= psr_we_nxt;
      psr_cwp     <= psr_cwp_nxt;
      psr_ps      <= psr_ps_nxt;
      psr_s       <= psr_s_nxt;
      psr_et      <= psr_et_nxt;
      tt          <= tt_nxt;
      error_mode  <= error_mode_nxt;
    end
  end

endmodule

// File: tb/tb_branch_trap_sequencer.sv
// Directed bench for branch_trap_sequencer with hand-computed expectations.
// ctl packs {pc_sel[1:0], annul, stall, save_pc_we, save_npc_we, psr_we, error_mode};
// psr packs {psr_cwp[1:0], psr_ps, psr_s, psr_et}.
module tb_branch_trap_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid, is_bicc, is_ticc, annul_bit, bcond, tcond;
  logic [3:0] cond;
  logic [6:0] sw_trap;
  logic       trap_req;
  logic [7:0] trap_type_in;
  logic       et, s;
  logic [1:0] cwp;
  logic [1:0] pc_sel, psr_cwp;
  logic       annul, stall, save_pc_we, save_npc_we, psr_we;
  logic       psr_ps, psr_s, psr_et, error_mode;
  logic [7:0] tt;

  int checks = 0;
  int errors = 0;

  branch_trap_sequencer #(.NWIN(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .is_bicc(is_bicc),
    .is_ticc(is_ticc), .cond(cond), .annul_bit(annul_bit), .bcond(bcond),
    .tcond(tcond), .sw_trap(sw_trap), .trap_req(trap_req),
    .trap_type_in(trap_type_in), .et(et), .s(s), .cwp(cwp),
    .pc_sel(pc_sel), .annul(annul), .stall(stall), .save_pc_we(save_pc_we),
    .save_npc_we(save_npc_we), .psr_we(psr_we), .psr_cwp(psr_cwp),
    .psr_ps(psr_ps), .psr_s(psr_s), .psr_et(psr_et), .tt(tt),
    .error_mode(error_mode)
  );

  always #5 clk = ~clk;

  wire [7:0] ctl = {pc_sel, annul, stall, save_pc_we, save_npc_we, psr_we, error_mode};
  wire [4:0] psr = {psr_cwp, psr_ps, psr_s, psr_et};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    instr_valid = 0; is_bicc = 0; is_ticc = 0; cond = 4'h0; annul_bit = 0;
    bcond = 0; tcond = 0; sw_trap = 7'h00; trap_req = 0; trap_type_in = 8'h00;
  endtask

  task automatic bicc(input logic [3:0] c, input logic a, input logic b);
    idle();
    instr_valid = 1; is_bicc = 1; cond = c; annul_bit = a; bcond = b;
  endtask

  task automatic ticc(input logic [6:0] n);
    idle();
    instr_valid = 1; is_ticc = 1; tcond = 1; sw_trap = n;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 0; et = 1; s = 0; cwp = 2'd0;
    step(); step();
    check("reset_ctl", ctl, 8'h00);
    check("reset_tt", tt, 8'h00);
    check("reset_psr", psr, 5'h00);
    rst_n = 1;
    step();
    check("idle_after_reset", ctl, 8'h00);

    // bne,a taken: branch target, no annul
    bicc(4'b1001, 1, 1); step();
    check("bne_taken", ctl, 8'b01_000000);
    idle(); step();
    check("bne_return_seq", ctl, 8'h00);

    // ba,a taken: branch target plus one-cycle annul; delay-slot Bicc squashed
    bicc(4'b1000, 1, 1); step();
    check("ba_a_taken", ctl, 8'b01_100000);
    bicc(4'b1001, 0, 1); step();
    check("ba_a_slot_squashed", ctl, 8'h00);
    idle(); step();
    check("ba_a_after", ctl, 8'h00);

    // DCTI couple: taken Bicc in delay slot of taken Bicc is processed
    bicc(4'b1001, 0, 1); step();
    check("dcti_first", ctl, 8'b01_000000);
    bicc(4'b0001, 0, 1); step();
    check("dcti_second", ctl, 8'b01_000000);

    // untaken Bicc,a with taken Ticc in the slot: annul, no trap
    bicc(4'b0001, 1, 0); step();
    check("untaken_a", ctl, 8'b00_100000);
    ticc(7'h11); step();
    check("untaken_a_slot_ticc", ctl, 8'h00);
    idle(); step();
    check("untaken_a_no_trap", ctl, 8'h00);

    // Ticc 5, et=1 s=0 cwp=0
    et = 1; s = 0; cwp = 2'd0;
    ticc(7'h05); step();
    check("ticc_save_pc", ctl, 8'b00_011000);
    check("ticc_tt_pc", tt, 8'h85);
    idle(); step();
    check("ticc_save_npc", ctl, 8'b00_010100);
    check("ticc_tt_npc", tt, 8'h85);
    step();
    check("ticc_vector", ctl, 8'b10_010010);
    check("ticc_tt_vec", tt, 8'h85);
    check("ticc_psr", psr, 5'b11_0_1_0);
    step();
    check("ticc_back_run", ctl, 8'h00);

    // trap_req 2A beats Ticc; trap_req during T_SAVE_NPC ignored
    et = 1; s = 1; cwp = 2'd2;
    ticc(7'h05); trap_req = 1; trap_type_in = 8'h2A; step();
    check("treq_save_pc", ctl, 8'b00_011000);
    check("treq_tt", tt, 8'h2A);
    idle(); step();
    check("treq_save_npc", ctl, 8'b00_010100);
    instr_valid = 1; trap_req = 1; trap_type_in = 8'h33; step();
    check("treq_vector", ctl, 8'b10_010010);
    check("treq_tt_vec", tt, 8'h2A);
    check("treq_psr", psr, 5'b01_1_1_0);
    idle(); step();
    check("treq_done", ctl, 8'h00);
    step();
    check("treq_single_seq", ctl, 8'h00);

    // trap_req without instr_valid is not acted on
    trap_req = 1; trap_type_in = 8'h44; step();
    check("treq_no_valid", ctl, 8'h00);
    idle();

    // Ticc with et=0: error mode, held until reset
    et = 0;
    ticc(7'h05); step();
    check("err_enter", ctl, 8'b00_010001);
    idle();
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) bicc(4'b1000, 1, 1); else ticc(7'h01);
      step();
      check($sformatf("err_hold_%0d", i), ctl, 8'b00_010001);
    end
    idle(); rst_n = 0; step();
    check("err_reset_ctl", ctl, 8'h00);
    check("err_reset_tt", tt, 8'h00);
    rst_n = 1; et = 1;
    step();
    check("err_reset_run", ctl, 8'h00);

    // reset during T_SAVE_NPC: no psr_we afterwards
    ticc(7'h02); step();
    check("abort_save_pc", ctl, 8'b00_011000);
    idle(); step();
    check("abort_save_npc", ctl, 8'b00_010100);
    rst_n = 0; step();
    check("abort_reset", ctl, 8'h00);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("abort_no_psr_we_%0d", i), ctl, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
